// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the write-back stage.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_nzp;

  // Write-back source select; the unused encoding 2'b11 is treated as ALU.
  typedef enum logic [1:0] {
    ALU = 2'b00,
    MEM = 2'b01,
    PC  = 2'b10
  } lc3b_wb_sel;

  typedef struct packed {
    lc3b_reg    dr;
    logic       load_regfile;
    logic       load_cc;
    lc3b_wb_sel wb_sel;
  } lc3b_ipacket;

  localparam lc3b_nzp NzpReset = 3'b010;

endpackage

// File: rtl/wb_stage_cc_gen.sv
// Condition-code generator: one-hot n/z/p from a 16-bit result.
module cc_gen
  import lc3b_types::*;
(
  input  lc3b_word value,
  output lc3b_nzp  nzp
);

  // Negative wins on bit 15, zero on all-clear, positive otherwise.
  always_comb begin
    nzp = 3'b001;
    if (value[15]) begin
      nzp = 3'b100;
    end else if (value == 16'h0000) begin
      nzp = 3'b010;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: single pipeline register, register-file write, CC update,
// bypass to ID/EX and retired-instruction counter.
module wb_stage
  import lc3b_types::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  lc3b_ipacket         mem_ipacket,
  input  logic [15:0]         mem_pc,
  input  logic [15:0]         mem_alu,
  input  logic [15:0]         mem_rdata,
  input  logic                hold,
  output logic [2:0]          dr,
  output logic [15:0]         wbdata,
  output logic [15:0]         wbpc,
  output logic                regfile_mux_sel,
  output logic                load_regfile,
  output logic [2:0]          nzp,
  output logic                fwd_valid,
  output logic [2:0]          fwd_reg,
  output logic [15:0]         fwd_data,
  output logic [RETIRE_W-1:0] retired
);

  logic                valid_q;
  lc3b_ipacket         ipacket_q;
  lc3b_word            pc_q;
  lc3b_word            alu_q;
  lc3b_word            rdata_q;
  lc3b_nzp             nzp_q;
  logic [RETIRE_W-1:0] retired_q;

  logic     commit;
  logic     capture;
  lc3b_word final_val;
  lc3b_nzp  cc_nzp;

  // Handshake: the stage frees up whenever its occupant commits this cycle.
  always_comb begin
    mem_ready = !valid_q || !hold;
    commit    = valid_q && !hold;
    capture   = mem_valid && mem_ready;
  end

  // Write-back source decode and final value selection.
  always_comb begin
    wbdata          = alu_q;
    regfile_mux_sel = 1'b1;
    case (ipacket_q.wb_sel)
      MEM:     wbdata = rdata_q;
      PC:      regfile_mux_sel = 1'b0;
      default: ;
    endcase
    final_val = regfile_mux_sel ? wbdata : pc_q;
  end

  cc_gen u_cc_gen (
    .value(final_val),
    .nzp  (cc_nzp)
  );

  // Outputs driven only from registered state.
  always_comb begin
    dr           = ipacket_q.dr;
    wbpc         = pc_q;
    load_regfile = commit && ipacket_q.load_regfile;
    nzp          = nzp_q;
    fwd_valid    = valid_q && ipacket_q.load_regfile;
    fwd_reg      = ipacket_q.dr;
    fwd_data     = final_val;
    retired      = retired_q;
  end

  // Pipeline register, condition codes and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ipacket_q <= '0;
      pc_q      <= '0;
      alu_q     <= '0;
      rdata_q   <= '0;
      nzp_q     <= NzpReset;
      retired_q <= '0;
    end else begin
      if (capture) begin
        valid_q   <= 1'b1;
        ipacket_q <= mem_ipacket;
        pc_q      <= mem_pc;
        alu_q     <= mem_alu;
        rdata_q   <= mem_rdata;
      end else if (commit) begin
        valid_q <= 1'b0;
      end
      if (commit && ipacket_q.load_cc) begin
        nzp_q <= cc_nzp;
      end
      if (commit) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter RETIRE_W, default 16, SHALL set the width of the retired-instruction counter.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 mem_valid  in  1  SHALL indicate that the MEM-stage payload is valid.
REQ-005 mem_ready  out  1  SHALL indicate that the stage accepts the payload this cycle.
REQ-006 mem_ipacket  in  lc3b_ipacket  SHALL carry dr, load_regfile, load_cc and wb_sel.
REQ-007 mem_pc  in  16  SHALL carry the incremented PC of the instruction.
REQ-008 mem_alu  in  16  SHALL carry the ALU/address result.
REQ-009 mem_rdata  in  16  SHALL carry the memory read data.
REQ-010 hold  in  1  SHALL be the stall/debug-halt request; it blocks commit.
REQ-011 dr  out  3  SHALL be the register-file write index.
REQ-012 wbdata  out  16  SHALL be the ALU or memory result.
REQ-013 wbpc  out  16  SHALL be the link PC.
REQ-014 regfile_mux_sel  out  1  SHALL select the write source: 0 = wbpc, 1 = wbdata.
REQ-015 load_regfile  out  1  SHALL be the register-file write enable.
REQ-016 nzp  out  3  SHALL be the condition-code register.
REQ-017 fwd_valid, fwd_reg, fwd_data  out  1/3/16  SHALL form the bypass to ID/EX.
REQ-018 retired  out  RETIRE_W  SHALL be the count of committed instructions.

Function
REQ-019 A single pipeline register (valid_q plus payload) SHALL capture the inputs when mem_valid && mem_ready.
REQ-020 mem_ready SHALL equal !valid_q || !hold.
REQ-021 commit SHALL equal valid_q && !hold; each accepted instruction SHALL commit exactly once.
REQ-022 load_regfile SHALL equal commit && ipacket_q.load_regfile, driven combinationally from registered state only.
REQ-023 wb_sel decode: ALU -> wbdata = alu_q, mux_sel 1; MEM -> wbdata = rdata_q, mux_sel 1; PC -> mux_sel 0; wbpc = pc_q always.
REQ-024 wb_sel encoding 2'b11 SHALL behave as ALU.
REQ-025 The final value SHALL be (mux_sel ? wbdata : wbpc).
REQ-026 On commit && load_cc, nzp SHALL load from the final value: n = bit15; z = all-zero; p otherwise; exactly one bit set.
REQ-027 nzp SHALL hold otherwise.
REQ-028 fwd_valid SHALL equal valid_q && ipacket_q.load_regfile, independent of hold.
REQ-029 fwd_reg SHALL equal dr_q, and fwd_data SHALL equal the final value.
REQ-030 retired SHALL increment by 1 per commit, wrapping from all-ones to 0.
REQ-031 Back-to-back: when commit and capture occur in the same cycle, the new payload SHALL replace the old, sustaining one instruction per cycle.
REQ-032 While hold && valid_q, all outputs SHALL stay stable, load_regfile SHALL be 0, and no capture SHALL occur.
REQ-033 With valid_q = 0, load_regfile SHALL be 0, fwd_valid SHALL be 0, and nzp/retired SHALL be unchanged.
REQ-034 MEM SHALL keep its payload stable while mem_valid && !mem_ready; wb_stage relies on this.

Reset
REQ-035 Assertion of rst_n = 0 SHALL immediately clear valid_q, load_regfile, fwd_valid and retired, and set nzp = 3'b010.
REQ-036 Payload registers SHALL reset to 0, so that dr, wbdata, wbpc and fwd_data read 0 and regfile_mux_sel reads 1.
REQ-037 Reset mid-operation SHALL discard the in-flight instruction with no register write, no nzp update and no count.

Structure
REQ-038 lc3b_types SHALL gain the lc3b_wb_sel enum {ALU, MEM, PC}, the lc3b_nzp typedef, and the ipacket fields load_cc and wb_sel.
REQ-039 One combinational sub-module cc_gen (16-bit in, lc3b_nzp out) SHALL implement REQ-026.

Verification
REQ-040 Reset, then ADD with alu = 16'h8000, load_cc, dr = 3 -> one cycle later load_regfile = 1, dr = 3, wbdata = 8000, nzp = 100, retired = 1.
REQ-041 JSR with pc = 16'h3002, wb_sel = PC, dr = 7 -> regfile_mux_sel = 0, wbpc = 3002, fwd_data = 3002.
REQ-042 Three back-to-back LDR with rdata 0/5/FFFF, load_cc -> mem_ready stays 1, nzp sequence 010/001/100, retired = 3.
REQ-043 hold asserted 4 cycles with valid_q -> mem_ready = 0, load_regfile = 0, fwd_valid = 1, then exactly one write after release.
REQ-044 rst_n low while valid_q = 1 -> no write, nzp = 010, retired = 0; retired preloaded to 16'hFFFF then one commit -> 0.
